// File: rtl/myff_bank.sv
// Bank of independent registered channels, each selecting between clocked data and a
// separately loaded value, with a saturating per-channel count of accepted loads.
module myff_bank #(
    parameter int unsigned     WIDTH     = 8,
    parameter int unsigned     CHANNELS  = 4,
    parameter int unsigned     LOAD_MODE = 0,
    parameter logic [WIDTH-1:0] RST_VAL  = '0,
    parameter int unsigned     CNT_W     = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [CHANNELS-1:0]         ce,
    input  logic [CHANNELS*WIDTH-1:0]   d,
    input  logic [CHANNELS-1:0]         aload,
    input  logic [CHANNELS*WIDTH-1:0]   rval,
    output logic [CHANNELS*WIDTH-1:0]   q,
    output logic [CHANNELS-1:0]         from_clock,
    output logic [CHANNELS*CNT_W-1:0]   load_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic             EDGE_MODE = (LOAD_MODE != 0);

    logic [CHANNELS-1:0][WIDTH-1:0] data_q, data_d;
    logic [CHANNELS-1:0][WIDTH-1:0] lval_q, lval_d;
    logic [CHANNELS-1:0][WIDTH-1:0] q_q, q_d;
    logic [CHANNELS-1:0][CNT_W-1:0] cnt_q, cnt_d;
    logic [CHANNELS-1:0]            flag_q, flag_d;
    logic [CHANNELS-1:0]            adly_q, adly_d;
    logic [CHANNELS-1:0]            accept;

    // Next state per channel; q is pre-selected from next state so the output is a plain flop.
    always_comb begin
        data_d = data_q;
        lval_d = lval_q;
        cnt_d  = cnt_q;
        flag_d = flag_q;
        adly_d = aload;
        accept = '0;
        q_d    = q_q;
        for (int n = 0; n < int'(CHANNELS); n++) begin
            accept[n] = aload[n] & (~EDGE_MODE | ~adly_q[n]);
            if (ce[n]) begin
                data_d[n] = d[n*WIDTH +: WIDTH];
            end
            if (accept[n]) begin
                lval_d[n] = rval[n*WIDTH +: WIDTH];
                flag_d[n] = 1'b0;
                if (cnt_q[n] != CNT_MAX) begin
                    cnt_d[n] = cnt_q[n] + CNT_W'(1);
                end
            end else if (ce[n]) begin
                flag_d[n] = 1'b1;
            end
            q_d[n] = flag_d[n] ? data_d[n] : lval_d[n];
        end
    end

    // The delay bit keeps tracking aload through reset so a held request is not seen as an edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            data_q <= {CHANNELS{RST_VAL}};
            lval_q <= {CHANNELS{RST_VAL}};
            q_q    <= {CHANNELS{RST_VAL}};
            cnt_q  <= '0;
            flag_q <= '0;
            adly_q <= aload;
        end else begin
            data_q <= data_d;
            lval_q <= lval_d;
            q_q    <= q_d;
            cnt_q  <= cnt_d;
            flag_q <= flag_d;
            adly_q <= adly_d;
        end
    end

    assign q          = q_q;
    assign from_clock = flag_q;
    assign load_cnt   = cnt_q;

endmodule
